// File: rtl/bram_read_arbiter_pkg.sv
// Shared encodings for the two-requester BRAM read arbiter:
// FSM states, requester ids and a small helper mapping an id to its grant state.
package bram_read_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_e;

    localparam logic REQ_ID0 = 1'b0;
    localparam logic REQ_ID1 = 1'b1;

    function automatic state_e grant_state(input logic id);
        return (id == REQ_ID1) ? GRANT1 : GRANT0;
    endfunction

endpackage

// File: rtl/bram_rd_tag_pipe.sv
// Return-path delay line: carries {valid, requester tag} alongside the BRAM
// read latency so returning data can be routed to whoever issued it.
module bram_rd_tag_pipe #(
    parameter int READ_LATENCY = 2,
    parameter int TAG_W        = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             vld_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             vld_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             any_vld_o
);

    logic [READ_LATENCY-1:0]            vld_pipe_q;
    logic [READ_LATENCY-1:0][TAG_W-1:0] tag_pipe_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_pipe_q <= '0;
            tag_pipe_q <= '0;
        end else begin
            vld_pipe_q[0] <= vld_i;
            tag_pipe_q[0] <= tag_i;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_pipe_q[i] <= vld_pipe_q[i-1];
                tag_pipe_q[i] <= tag_pipe_q[i-1];
            end
        end
    end

    assign vld_o     = vld_pipe_q[READ_LATENCY-1];
    assign tag_o     = tag_pipe_q[READ_LATENCY-1];
    assign any_vld_o = |vld_pipe_q;

endmodule

// File: rtl/bram_read_arbiter.sv
// Two-requester round-robin arbiter for a single BRAM read port with bounded
// bursts, zero-bubble hand-over and in-order tagged data return.
module bram_read_arbiter
    import bram_read_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 12,
    parameter int READ_LATENCY = 2,
    parameter int MAX_BURST    = 16
) (
    input  logic                  S_AXIS_ACLK,
    input  logic                  S_AXIS_ARESET,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic                  bram_en,
    input  logic [DATA_WIDTH-1:0] bram_data,
    output logic                  busy
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            last_q, last_d;

    logic            beat;
    logic            cur_id;
    logic            own_req, oth_req, burst_done;
    logic            ret_vld, ret_tag, pipe_busy;

    always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
        if (S_AXIS_ARESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= REQ_ID1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        own_req    = (state_q == GRANT1) ? req1 : req0;
        oth_req    = (state_q == GRANT1) ? req0 : req1;
        burst_done = beat && (cnt_q == CNT_LAST);
        case (state_q)
            IDLE: begin
                if (req0 && (!req1 || last_q == REQ_ID1)) state_d = GRANT0;
                else if (req1)                            state_d = GRANT1;
            end
            GRANT0, GRANT1: begin
                if (!own_req || burst_done) begin
                    if (oth_req)      state_d = grant_state(~cur_id);
                    else if (!own_req) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A full burst with no contender re-arms the same grant with a fresh count.
        if (state_d != state_q || burst_done) cnt_d = '0;
        else if (beat)                        cnt_d = cnt_q + CW'(1);
        if (state_d != state_q && state_d == GRANT0) last_d = REQ_ID0;
        if (state_d != state_q && state_d == GRANT1) last_d = REQ_ID1;
    end

    always_comb begin
        gnt0      = (state_q == GRANT0);
        gnt1      = (state_q == GRANT1);
        cur_id    = gnt1 ? REQ_ID1 : REQ_ID0;
        beat      = (gnt0 && req0) || (gnt1 && req1);
        bram_en   = beat;
        bram_addr = gnt0 ? addr0 : (gnt1 ? addr1 : '0);
        rvalid0   = ret_vld && (ret_tag == REQ_ID0);
        rvalid1   = ret_vld && (ret_tag == REQ_ID1);
        rdata0    = bram_data;
        rdata1    = bram_data;
        busy      = (state_q != IDLE) || pipe_busy;
    end

    bram_rd_tag_pipe #(
        .READ_LATENCY (READ_LATENCY),
        .TAG_W        (1)
    ) u_tag_pipe (
        .clk_i     (S_AXIS_ACLK),
        .rst_i     (S_AXIS_ARESET),
        .vld_i     (beat),
        .tag_i     (cur_id),
        .vld_o     (ret_vld),
        .tag_o     (ret_tag),
        .any_vld_o (pipe_busy)
    );

endmodule

// File: tb/tb_bram_read_arbiter.sv
// Bench for bram_read_arbiter: directed scenarios plus randomized request
// traffic, compared cycle by cycle against a transaction-level arbiter model.
module tb_bram_read_arbiter;

    localparam int DW = 32;
    localparam int AW = 12;
    localparam int RL = 2;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1;
    logic [AW-1:0] addr0, addr1;
    logic          gnt0, gnt1, rvalid0, rvalid1, bram_en, busy;
    logic [DW-1:0] rdata0, rdata1, bram_data;
    logic [AW-1:0] bram_addr;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    bram_read_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(RL), .MAX_BURST(MB)
    ) u_dut (
        .S_AXIS_ACLK(clk), .S_AXIS_ARESET(rst),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .gnt0(gnt0), .gnt1(gnt1), .rdata0(rdata0), .rdata1(rdata1),
        .rvalid0(rvalid0), .rvalid1(rvalid1),
        .bram_addr(bram_addr), .bram_en(bram_en), .bram_data(bram_data),
        .busy(busy)
    );

    function automatic logic [DW-1:0] memfn(input logic [AW-1:0] a);
        return 32'h9E3779B1 * {20'd0, a} + 32'h0000_1234;
    endfunction

    // Behavioural BRAM: data for an enabled address appears RL cycles later.
    logic [DW-1:0] dl [RL];
    always @(posedge clk) begin
        dl[0] <= bram_en ? memfn(bram_addr) : 32'hDEAD_BEEF;
        for (int i = 1; i < RL; i++) dl[i] <= dl[i-1];
    end
    assign bram_data = dl[RL-1];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h (check %0d)", tag, got, exp, checks);
        end
    endtask

    // Model: who owns the port, beats in this tenure, who wins the next tie,
    // and the list of outstanding reads with the cycle they are due back.
    typedef struct { int due; int id; logic [AW-1:0] a; } ret_t;
    ret_t q[$];
    int   owner = -1, nb = 0, prefer = 0, cyc = 0;

    task automatic step(input logic r0, input logic r1,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        logic          rq_o, rq_x, ev, bt;
        logic [AW-1:0] ea;
        int            fid, nw, o;
        ret_t          fr;
        @(negedge clk);
        rst = 1'b0; req0 = r0; req1 = r1; addr0 = a0; addr1 = a1;
        #1;
        bt = (owner == 0 && r0) || (owner == 1 && r1);
        ea = (owner == 0) ? a0 : ((owner == 1) ? a1 : '0);
        ev = (q.size() > 0) && (q[0].due == cyc);
        fid = ev ? q[0].id : -1;
        chk("gnt0", gnt0, owner == 0);
        chk("gnt1", gnt1, owner == 1);
        chk("bram_en", bram_en, bt);
        chk("bram_addr", bram_addr, ea);
        chk("busy", busy, (owner >= 0) || (q.size() > 0));
        chk("rvalid0", rvalid0, fid == 0);
        chk("rvalid1", rvalid1, fid == 1);
        if (ev) begin
            fr = q.pop_front();
            chk(fr.id == 0 ? "rdata0" : "rdata1", fr.id == 0 ? rdata0 : rdata1, memfn(fr.a));
        end
        if (bt) q.push_back('{cyc + RL, owner, ea});
        if (owner < 0) begin
            if (r0 && r1) nw = prefer;
            else if (r0)  nw = 0;
            else if (r1)  nw = 1;
            else          nw = -1;
            if (nw >= 0) begin owner = nw; prefer = 1 - nw; nb = 0; end
        end else begin
            o    = owner;
            rq_o = (o == 0) ? r0 : r1;
            rq_x = (o == 0) ? r1 : r0;
            if (rq_o) nb++;
            if (!rq_o || nb == MB) begin
                if (rq_x)      begin owner = 1 - o; prefer = o; nb = 0; end
                else if (rq_o) nb = 0;
                else           begin owner = -1; nb = 0; end
            end
        end
        cyc++;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        #1;
        chk("rst_gnt0", gnt0, 1'b0);
        chk("rst_gnt1", gnt1, 1'b0);
        chk("rst_en", bram_en, 1'b0);
        chk("rst_addr", bram_addr, '0);
        chk("rst_rvalid0", rvalid0, 1'b0);
        chk("rst_rvalid1", rvalid1, 1'b0);
        chk("rst_busy", busy, 1'b0);
        q.delete();
        owner = -1; nb = 0; prefer = 0;
        cyc++;
    endtask

    initial begin
        int p0, p1;
        logic [AW-1:0] ra;
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
        repeat (2) @(posedge clk);
        reset_pulse();

        // Single requester streaming a short address run.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, AW'(12'h010 + i), '0);
        repeat (RL + 2) step(1'b0, 1'b0, '0, '0);

        // Both held: alternating full bursts with no idle gap.
        for (int i = 0; i < 24; i++) step(1'b1, 1'b1, AW'(12'h100 + i), AW'(12'h200 + i));
        repeat (RL + 2) step(1'b0, 1'b0, '0, '0);

        // Requester 1 alone for a long run: burst limit re-arms the same grant.
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1, '0, AW'(12'h300 + i));
        repeat (RL + 2) step(1'b0, 1'b0, '0, '0);

        // Requester 0 drops while 1 waits; its in-flight beats still return.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, AW'(12'h400 + i), 12'h500);
        step(1'b0, 1'b1, 12'h7FF, 12'h501);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, '0, AW'(12'h502 + i));
        repeat (RL + 2) step(1'b0, 1'b0, '0, '0);

        // Reset with reads in flight, then contended request goes to 0.
        step(1'b0, 1'b1, '0, 12'h600);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, '0, AW'(12'h601 + i));
        reset_pulse();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, AW'(12'h700 + i), AW'(12'h710 + i));
        repeat (RL + 2) step(1'b0, 1'b0, '0, '0);

        // Randomized traffic with varying request densities.
        for (int blk = 0; blk < 30; blk++) begin
            p0 = $urandom_range(0, 100);
            p1 = $urandom_range(0, 100);
            for (int i = 0; i < 60; i++) begin
                ra = AW'($urandom_range(0, 4095));
                step($urandom_range(0, 99) < p0, $urandom_range(0, 99) < p1,
                     ra, AW'($urandom_range(0, 4095)));
            end
            if ($urandom_range(0, 9) == 0) reset_pulse();
        end
        repeat (RL + 3) step(1'b0, 1'b0, '0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
